// File: rtl/decoder_scan_nbit_pkg.sv
// Shared definitions for the decoder/scan block: mode encodings and FSM states.
package decoder_scan_nbit_pkg;

    // Mode field encodings; 2'b11 is reserved and decodes like MODE_ONEHOT.
    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;

    // Controller states.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StScan = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_scan_nbit_core.sv
// Combinational index decoder: one-hot (bit idx set) or thermometer (bits 0..idx set).
module decoder_core #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]    idx,
    input  logic            therm,
    output logic [2**N-1:0] y
);

    // Each output bit compares its own position against the index.
    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < 2**N; i++) begin
            y[i] = therm ? (idx >= N'(i)) : (idx == N'(i));
        end
    end

endmodule

// File: rtl/decoder_scan_nbit.sv
// Registered N-to-2**N decoder with direct one-hot/thermometer modes and a timed scan mode.
module decoder_scan_nbit
    import decoder_scan_nbit_pkg::*;
#(
    parameter int unsigned N       = 3,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       a,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    y,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    localparam logic [N-1:0] LastStep = {N{1'b1}};

    state_e             state_q, state_d;
    logic [N-1:0]       step_q, step_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [2**N-1:0]    y_q, y_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [N-1:0]       core_idx;
    logic               core_therm;
    logic [2**N-1:0]    core_y;

    // Next-state logic for the controller, step index, dwell counter and done pulse.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (mode == MODE_SCAN && enable && start) begin
                    state_d = StScan;
                    step_d  = '0;
                    cnt_d   = '0;
                    dwell_d = dwell;
                end
            end
            StScan: begin
                if (!enable) begin
                    // Abort: no done pulse.
                    state_d = StIdle;
                    step_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    if (step_q == LastStep) begin
                        state_d = StIdle;
                        step_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        step_d = step_q + N'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // The single decoder sees the upcoming step while scanning, otherwise the direct index.
    assign core_idx   = (state_d == StScan) ? step_d : a;
    assign core_therm = (state_d == StIdle) && (mode == MODE_THERM);

    decoder_core #(
        .N (N)
    ) u_core (
        .idx   (core_idx),
        .therm (core_therm),
        .y     (core_y)
    );

    // Next output values; leaving a scan (finish or abort) always yields a zero cycle.
    always_comb begin
        y_d     = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (state_d == StScan) begin
            y_d     = core_y;
            valid_d = 1'b1;
            busy_d  = 1'b1;
        end else if (state_q == StIdle && enable && mode != MODE_SCAN) begin
            y_d     = core_y;
            valid_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            step_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/decoder_scan_nbit.md
DECODER_SCAN_NBIT -- requirements
Module: decoder_scan_nbit

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the select width; output width is 2**N.
REQ-002 The block SHALL have parameter DWELL_W, default 4, meaning the dwell counter width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port a, input, N, the select index used in direct modes.
REQ-006 The block SHALL have port enable, input, 1, the global enable; low forces outputs to zero and aborts a scan.
REQ-007 The block SHALL have port mode, input, 2, where 00 = one-hot direct, 01 = thermometer direct, 10 = scan, and 11 = reserved (treated as 00).
REQ-008 The block SHALL have port start, input, 1, a single-cycle pulse that launches a scan.
REQ-009 The block SHALL have port dwell, input, DWELL_W, giving cycles-per-step minus one during a scan.
REQ-010 The block SHALL have port y, output, 2**N, the registered decoded output.
REQ-011 The block SHALL have port valid, output, 1, asserted when y holds a decode of current inputs or an active scan step.
REQ-012 The block SHALL have port busy, output, 1, asserted while in the SCAN state.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse on normal scan completion.

Function
REQ-014 The FSM SHALL have states IDLE and SCAN only.
REQ-015 In IDLE with mode 00 or 11, y SHALL update one cycle later to the one-hot vector with bit a set when enable=1, else all zero.
REQ-016 In IDLE with mode 01, y SHALL update one cycle later to bits 0..a set and the rest clear (thermometer) when enable=1, else all zero.
REQ-017 In IDLE, valid SHALL equal the enable value registered with the same one-cycle latency as y, and SHALL be 0 in mode 10.
REQ-018 In IDLE with mode 10, y SHALL be all zero.
REQ-019 IDLE SHALL transition to SCAN when mode=10, enable=1 and start=1 occur in the same cycle; the step index and dwell counter SHALL be cleared, and the dwell value SHALL be captured.
REQ-020 In SCAN, y SHALL be the one-hot encoding of the step index, and busy and valid SHALL both be 1, starting the cycle after the start pulse.
REQ-021 In SCAN, each step SHALL be held for exactly captured dwell+1 cycles; a dwell of 0 SHALL give one cycle per step.
REQ-022 When the dwell counter reaches the captured dwell, the step index SHALL increment, with no wrap inside a scan.
REQ-023 When the final step (index 2**N-1) completes its dwell, the FSM SHALL return to IDLE, and on the next cycle done=1 for one cycle while y=0, valid=0 and busy=0.
REQ-024 A scan of 2**N steps SHALL occupy exactly 2**N*(dwell+1) cycles of busy.
REQ-025 If enable=0 in SCAN, the FSM SHALL return to IDLE (abort), with y=0, busy=0 and valid=0 on the next cycle and no done pulse.
REQ-026 In SCAN, start, a, mode and dwell SHALL be ignored; changes to dwell SHALL take effect only at the next launch.
REQ-027 A start pulse in IDLE with mode other than 10 or with enable=0 SHALL be ignored.
REQ-028 A start pulse arriving in the same cycle as done SHALL launch a new scan, since the FSM is already in IDLE.

Reset
REQ-029 While reset=1 at a clock edge, the state SHALL become IDLE and y=0, valid=0, busy=0, done=0, with step and dwell counters at 0.
REQ-030 Reset SHALL take priority over all inputs, including mid-scan, and no done pulse SHALL follow a reset abort.

Structure
REQ-031 A shared package SHALL hold the mode encodings (MODE_ONEHOT, MODE_THERM, MODE_SCAN) and the FSM state encoding.
REQ-032 The combinational one-hot/thermometer decode SHALL be a single sub-module, decoder_core, instantiated once and fed either a or the step index.

Verification (N=3, DWELL_W=4)
REQ-033 The bench SHALL drive mode=00, enable=1 and sweep a=0..7, and require y=00000001..10000000 one cycle after each a, with valid=1.
REQ-034 The bench SHALL drive mode=01, enable=1 and a=5, and require y=00111111 next cycle; it SHALL then drive enable=0 and require y=0 and valid=0 next cycle.
REQ-035 The bench SHALL drive mode=10, dwell=2 and a start pulse, and require busy=1 for 24 cycles, y stepping 00000001..10000000 with each value held 3 cycles, then done=1 for one cycle and y=0.
REQ-036 The bench SHALL drop enable during step 4 of a dwell=0 scan, and require y=0 and busy=0 next cycle with no done pulse.
REQ-037 The bench SHALL assert reset during step 2 of a scan, and require all outputs 0 next cycle, then launch a fresh start and require the scan to begin again at y=00000001.
REQ-038 The bench SHALL give a second start mid-scan and a start coincident with done, and require the mid-scan start to be ignored and the coincident start to launch back-to-back scans.
